// File: rtl/tinynpu_pkg.sv
// Shared types and sizing helpers for the TinyNPU load scheduler.
package tinynpu_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_FIRE,
    S_WAIT
  } sched_state_e;

  // Width of a credit counter able to hold 0..depth inclusive.
  function automatic int credit_w(input int depth);
    return $clog2(depth + 1);
  endfunction

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/tinynpu_sched_if.sv
// Requester-side and NPU-side load/MAC bus of the TinyNPU scheduler.
interface tinynpu_sched_if
  import tinynpu_pkg::*;
#(
  parameter int SIZE   = 4,
  parameter int NREQ   = 2,
  parameter int DATA_W = 8
);
  localparam int SEL_W = idx_w(SIZE);

  logic [NREQ-1:0]             req_val;
  logic [NREQ-1:0]             req_rdy;
  logic [NREQ-1:0]             req_is_w;
  logic [NREQ-1:0][SEL_W-1:0]  req_sel;
  logic [NREQ-1:0][DATA_W-1:0] req_data;
  logic [NREQ-1:0]             req_last;
  logic [DATA_W-1:0]           npu_data;
  logic                        npu_x_load_val;
  logic                        npu_w_load_val;
  logic [SEL_W-1:0]            npu_w_load_sel;
  logic                        npu_mac_val;
  logic                        npu_x_fifo_ren;
  logic                        npu_w_fifo_ren;
  logic                        npu_ostream_req;

  modport master (
    output req_val, req_is_w, req_sel, req_data, req_last,
    output npu_x_fifo_ren, npu_w_fifo_ren, npu_ostream_req,
    input  req_rdy, npu_data, npu_x_load_val, npu_w_load_val,
    input  npu_w_load_sel, npu_mac_val
  );

  modport slave (
    input  req_val, req_is_w, req_sel, req_data, req_last,
    input  npu_x_fifo_ren, npu_w_fifo_ren, npu_ostream_req,
    output req_rdy, npu_data, npu_x_load_val, npu_w_load_val,
    output npu_w_load_sel, npu_mac_val
  );

endinterface

// File: rtl/tinynpu_rr_arb.sv
// Round-robin arbiter: first requester at or after ptr wins, wrapping around.
module tinynpu_rr_arb
  import tinynpu_pkg::*;
#(
  parameter  int N  = 2,
  localparam int IW = idx_w(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx,
  output logic          valid
);

  // Two passes: indices >= ptr first, then the wrapped-around low indices.
  always_comb begin
    grant = '0;
    idx   = '0;
    valid = 1'b0;
    for (int c = 0; c < N; c++) begin
      if (!valid && req[c] && c >= int'(ptr)) begin
        valid    = 1'b1;
        grant[c] = 1'b1;
        idx      = IW'(c);
      end
    end
    for (int c = 0; c < N; c++) begin
      if (!valid && req[c]) begin
        valid    = 1'b1;
        grant[c] = 1'b1;
        idx      = IW'(c);
      end
    end
  end

endmodule

// File: rtl/tinynpu_sched.sv
// TinyNPU load scheduler: round-robin load port sharing, FIFO credit tracking, MAC start.
// Optional TINYNPU_SCHED_PERF_EN adds perf_batches/perf_stalls counters.
module tinynpu_sched
  import tinynpu_pkg::*;
#(
  parameter int SIZE   = 4,
  parameter int NREQ   = 2,
  parameter int DEPTH  = 4,
  parameter int DATA_W = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            cfg_start,
  input  logic [NREQ-1:0] cfg_req_mask,
  tinynpu_sched_if.slave  bus,
  output logic            sched_busy,
  output logic            sched_done,
  output logic            sched_err
`ifdef TINYNPU_SCHED_PERF_EN
  ,
  output logic [31:0]     perf_batches,
  output logic [31:0]     perf_stalls
`endif
);

  localparam int CW    = credit_w(DEPTH);
  localparam int SEL_W = idx_w(SIZE);
  localparam int PTR_W = idx_w(NREQ);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  sched_state_e    state_q, state_d;
  logic [NREQ-1:0] pending_q, pending_d;
  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic mac_q, mac_d, done_q, done_d, err_q, err_d;
  logic [CW-1:0] x_count_q, x_count_d;
  logic [CW-1:0] w_count_q [SIZE];
  logic [CW-1:0] w_count_d [SIZE];

  logic [NREQ-1:0]  eligible, grant;
  logic [PTR_W-1:0] gnt_idx;
  logic             gnt_any, x_load, w_load, balanced;
  logic [SEL_W-1:0] w_sel;

  // A beat is eligible only if its requester is pending and its target FIFO has room.
  always_comb begin
    eligible = '0;
    for (int r = 0; r < NREQ; r++) begin
      if (state_q == S_LOAD && bus.req_val[r] && pending_q[r]) begin
        if (bus.req_is_w[r]) eligible[r] = (w_count_q[bus.req_sel[r]] != FULL_CNT);
        else                 eligible[r] = (x_count_q != FULL_CNT);
      end
    end
  end

  tinynpu_rr_arb #(.N(NREQ)) u_arb (
    .req   (eligible),
    .ptr   (ptr_q),
    .grant (grant),
    .idx   (gnt_idx),
    .valid (gnt_any)
  );

  assign x_load = gnt_any && !bus.req_is_w[gnt_idx];
  assign w_load = gnt_any &&  bus.req_is_w[gnt_idx];
  assign w_sel  = w_load ? bus.req_sel[gnt_idx] : '0;

  assign bus.req_rdy        = grant;
  assign bus.npu_data       = gnt_any ? bus.req_data[gnt_idx] : '0;
  assign bus.npu_x_load_val = x_load;
  assign bus.npu_w_load_val = w_load;
  assign bus.npu_w_load_sel = w_sel;
  assign bus.npu_mac_val    = mac_q;

  assign sched_busy = (state_q != S_IDLE);
  assign sched_done = done_q;
  assign sched_err  = err_q;

  // Pops at zero are ignored, so a push alongside a dropped pop still counts up.
  always_comb begin
    x_count_d = x_count_q;
    if (x_load && !(bus.npu_x_fifo_ren && x_count_q != '0))      x_count_d = x_count_q + 1'b1;
    else if (!x_load && bus.npu_x_fifo_ren && x_count_q != '0)   x_count_d = x_count_q - 1'b1;
    for (int i = 0; i < SIZE; i++) begin
      w_count_d[i] = w_count_q[i];
      if ((w_load && w_sel == SEL_W'(i)) && !(bus.npu_w_fifo_ren && w_count_q[i] != '0))
        w_count_d[i] = w_count_q[i] + 1'b1;
      else if (!(w_load && w_sel == SEL_W'(i)) && bus.npu_w_fifo_ren && w_count_q[i] != '0)
        w_count_d[i] = w_count_q[i] - 1'b1;
    end
    balanced = (x_count_d != '0);
    for (int i = 0; i < SIZE; i++) begin
      if (w_count_d[i] != x_count_d) balanced = 1'b0;
    end
  end

  // MAC start is decided on the counts entering FIRE so it can be registered.
  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    ptr_d     = ptr_q;
    mac_d     = 1'b0;
    done_d    = 1'b0;
    err_d     = err_q;
    case (state_q)
      S_IDLE: if (cfg_start) begin
        err_d = 1'b0;
        if (cfg_req_mask == '0) done_d = 1'b1;
        else begin
          state_d   = S_LOAD;
          pending_d = cfg_req_mask;
        end
      end
      S_LOAD: begin
        if (pending_q == '0) begin
          state_d = S_FIRE;
          mac_d   = balanced;
        end else if (gnt_any) begin
          ptr_d = (gnt_idx == PTR_W'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
          if (bus.req_last[gnt_idx]) pending_d[gnt_idx] = 1'b0;
        end
      end
      S_FIRE: begin
        if (mac_q) state_d = S_WAIT;
        else begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_WAIT: if (bus.npu_ostream_req) begin
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      pending_q <= '0;
      ptr_q     <= '0;
      mac_q     <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      ptr_q     <= ptr_d;
      mac_q     <= mac_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_count_q <= '0;
      for (int i = 0; i < SIZE; i++) w_count_q[i] <= '0;
    end else begin
      x_count_q <= x_count_d;
      for (int i = 0; i < SIZE; i++) w_count_q[i] <= w_count_d[i];
    end
  end

`ifdef TINYNPU_SCHED_PERF_EN
  logic [31:0] perf_batches_q, perf_batches_d, perf_stalls_q, perf_stalls_d;
  logic        stall;

  // A stall is pending demand in LOAD that no FIFO could accept.
  assign stall = (state_q == S_LOAD) && |(bus.req_val & pending_q) && !gnt_any;

  always_comb begin
    perf_batches_d = perf_batches_q + (done_q ? 32'd1 : 32'd0);
    perf_stalls_d  = perf_stalls_q + (stall ? 32'd1 : 32'd0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_batches_q <= '0;
      perf_stalls_q  <= '0;
    end else begin
      perf_batches_q <= perf_batches_d;
      perf_stalls_q  <= perf_stalls_d;
    end
  end

  assign perf_batches = perf_batches_q;
  assign perf_stalls  = perf_stalls_q;
`endif

endmodule

// File: tb/tb_tinynpu_sched.sv
// Directed bench for tinynpu_sched: batch flow, round-robin, credit limits, error and reset.
module tb_tinynpu_sched;

  logic       clk = 1'b0;
  logic       rst;
  logic       cfg_start;
  logic [1:0] cfg_req_mask;
  logic       sched_busy, sched_done, sched_err;
  int         checkCount = 0;
  int         passCount  = 0;

  tinynpu_sched_if #(.SIZE(4), .NREQ(2), .DATA_W(8)) bus ();

  tinynpu_sched #(.SIZE(4), .NREQ(2), .DEPTH(4), .DATA_W(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .cfg_start    (cfg_start),
    .cfg_req_mask (cfg_req_mask),
    .bus          (bus),
    .sched_busy   (sched_busy),
    .sched_done   (sched_done),
    .sched_err    (sched_err)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checkCount++;
    if (obs === exp) passCount++;
    else $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic applyStimulus(input logic [1:0] val, input logic [1:0] isW,
                               input logic [1:0] last, input logic [3:0] sel,
                               input logic [15:0] data);
    bus.req_val  = val;
    bus.req_is_w = isW;
    bus.req_last = last;
    bus.req_sel  = sel;
    bus.req_data = data;
  endtask

  initial begin
    rst = 1'b1;
    cfg_start = 1'b0;
    cfg_req_mask = 2'b00;
    applyStimulus(2'b00, 2'b00, 2'b00, 4'h0, 16'h0000);
    bus.npu_x_fifo_ren = 1'b0;
    bus.npu_w_fifo_ren = 1'b0;
    bus.npu_ostream_req = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("rst_busy", 32'(sched_busy), 0);
    checkOutput("rst_done", 32'(sched_done), 0);
    checkOutput("rst_err", 32'(sched_err), 0);
    checkOutput("rst_mac", 32'(bus.npu_mac_val), 0);
    checkOutput("rst_xcnt", 32'(dut.x_count_q), 0);

    // Single requester: one x beat then w beats to sel 0..3.
    @(negedge clk);
    cfg_start = 1'b1; cfg_req_mask = 2'b01;
    #1 checkOutput("a_idle_rdy", 32'(bus.req_rdy), 0);
    @(negedge clk);
    cfg_start = 1'b0;
    applyStimulus(2'b01, 2'b00, 2'b00, 4'h0, 16'h0011);
    #1;
    checkOutput("a_busy", 32'(sched_busy), 1);
    checkOutput("a_x_rdy", 32'(bus.req_rdy), 1);
    checkOutput("a_x_load", 32'(bus.npu_x_load_val), 1);
    checkOutput("a_x_wload", 32'(bus.npu_w_load_val), 0);
    checkOutput("a_x_data", 32'(bus.npu_data), 32'h11);
    for (int s = 0; s < 4; s++) begin
      @(negedge clk);
      applyStimulus(2'b01, 2'b01, (s == 3) ? 2'b01 : 2'b00, 4'(s), 16'(8'h20 + s));
      #1;
      checkOutput("a_w_rdy", 32'(bus.req_rdy), 1);
      checkOutput("a_w_load", 32'(bus.npu_w_load_val), 1);
      checkOutput("a_w_sel", 32'(bus.npu_w_load_sel), 32'(s));
      checkOutput("a_w_data", 32'(bus.npu_data), 32'(8'h20 + s));
    end
    @(negedge clk);
    applyStimulus(2'b00, 2'b00, 2'b00, 4'h0, 16'h0000);
    #1;
    checkOutput("a_pre_mac", 32'(bus.npu_mac_val), 0);
    checkOutput("a_xcnt", 32'(dut.x_count_q), 1);
    checkOutput("a_w3cnt", 32'(dut.w_count_q[3]), 1);
    @(negedge clk);
    #1 checkOutput("a_mac", 32'(bus.npu_mac_val), 1);
    @(negedge clk);
    bus.npu_ostream_req = 1'b1;
    #1;
    checkOutput("a_mac_once", 32'(bus.npu_mac_val), 0);
    checkOutput("a_wait_done", 32'(sched_done), 0);
    @(negedge clk);
    bus.npu_ostream_req = 1'b0;
    #1;
    checkOutput("a_done", 32'(sched_done), 1);
    checkOutput("a_idle", 32'(sched_busy), 0);
    @(negedge clk);
    bus.npu_x_fifo_ren = 1'b1; bus.npu_w_fifo_ren = 1'b1;
    #1 checkOutput("a_done_pulse", 32'(sched_done), 0);
    @(negedge clk);
    bus.npu_x_fifo_ren = 1'b0; bus.npu_w_fifo_ren = 1'b0;
    #1;
    checkOutput("a_drain_x", 32'(dut.x_count_q), 0);
    checkOutput("a_drain_w0", 32'(dut.w_count_q[0]), 0);

    // Round-robin from reset, req0 -> x, req1 -> w0; ends unbalanced.
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    cfg_start = 1'b1; cfg_req_mask = 2'b11;
    @(negedge clk);
    cfg_start = 1'b0;
    applyStimulus(2'b11, 2'b10, 2'b00, 4'h0, 16'hB1A1);
    #1 checkOutput("b_g0", 32'(bus.req_rdy), 32'b01);
    checkOutput("b_g0_data", 32'(bus.npu_data), 32'hA1);
    @(negedge clk);
    #1 checkOutput("b_g1", 32'(bus.req_rdy), 32'b10);
    checkOutput("b_g1_data", 32'(bus.npu_data), 32'hB1);
    @(negedge clk);
    applyStimulus(2'b11, 2'b10, 2'b01, 4'h0, 16'hB1A1);
    #1 checkOutput("b_g2", 32'(bus.req_rdy), 32'b01);
    @(negedge clk);
    applyStimulus(2'b11, 2'b10, 2'b11, 4'h0, 16'hB1A1);
    #1 checkOutput("b_g3_skip_done", 32'(bus.req_rdy), 32'b10);
    @(negedge clk);
    #1 checkOutput("b_no_pending", 32'(bus.req_rdy), 0);
    @(negedge clk);
    applyStimulus(2'b00, 2'b00, 2'b00, 4'h0, 16'h0000);
    #1 checkOutput("b_fire_nomac", 32'(bus.npu_mac_val), 0);
    checkOutput("b_fire_busy", 32'(sched_busy), 1);
    @(negedge clk);
    #1 checkOutput("b_err", 32'(sched_err), 1);
    checkOutput("b_err_idle", 32'(sched_busy), 0);
    checkOutput("b_err_nomac", 32'(bus.npu_mac_val), 0);

    // Full x FIFO blocks grant; simultaneous push and pop hold the count.
    @(negedge clk);
    cfg_start = 1'b1; cfg_req_mask = 2'b01;
    @(negedge clk);
    cfg_start = 1'b0;
    applyStimulus(2'b01, 2'b00, 2'b00, 4'h0, 16'h0033);
    #1 checkOutput("c_err_clr", 32'(sched_err), 0);
    checkOutput("c_rdy_x2", 32'(bus.req_rdy), 1);
    @(negedge clk);
    #1 checkOutput("c_rdy_x3", 32'(bus.req_rdy), 1);
    @(negedge clk);
    bus.npu_x_fifo_ren = 1'b1;
    #1 checkOutput("c_full_rdy", 32'(bus.req_rdy), 0);
    checkOutput("c_full_cnt", 32'(dut.x_count_q), 4);
    checkOutput("c_full_noload", 32'(bus.npu_x_load_val), 0);
    @(negedge clk);
    bus.npu_x_fifo_ren = 1'b0;
    #1 checkOutput("c_pop_cnt", 32'(dut.x_count_q), 3);
    checkOutput("c_regrant", 32'(bus.req_rdy), 1);
    @(negedge clk);
    applyStimulus(2'b00, 2'b00, 2'b00, 4'h0, 16'h0000);
    bus.npu_x_fifo_ren = 1'b1;
    @(negedge clk);
    @(negedge clk);
    applyStimulus(2'b01, 2'b00, 2'b01, 4'h0, 16'h0044);
    #1 checkOutput("d_cnt_before", 32'(dut.x_count_q), 2);
    checkOutput("d_rdy", 32'(bus.req_rdy), 1);
    @(negedge clk);
    applyStimulus(2'b00, 2'b00, 2'b00, 4'h0, 16'h0000);
    bus.npu_x_fifo_ren = 1'b0;
    #1 checkOutput("d_cnt_hold", 32'(dut.x_count_q), 2);
    @(negedge clk);
    #1 checkOutput("d_nomac", 32'(bus.npu_mac_val), 0);
    @(negedge clk);
    #1 checkOutput("d_err", 32'(sched_err), 1);

    // Reset in the middle of a load.
    @(negedge clk);
    cfg_start = 1'b1; cfg_req_mask = 2'b01;
    @(negedge clk);
    cfg_start = 1'b0;
    applyStimulus(2'b01, 2'b01, 2'b00, 4'h1, 16'h0055);
    #1 checkOutput("e_rdy", 32'(bus.req_rdy), 1);
    checkOutput("e_sel", 32'(bus.npu_w_load_sel), 1);
    @(negedge clk);
    applyStimulus(2'b01, 2'b01, 2'b00, 4'h2, 16'h0066);
    @(negedge clk);
    applyStimulus(2'b01, 2'b01, 2'b00, 4'h3, 16'h0077);
    #1 checkOutput("e_pre_rst_rdy", 32'(bus.req_rdy), 1);
    rst = 1'b1;
    #1;
    checkOutput("e_rst_rdy", 32'(bus.req_rdy), 0);
    checkOutput("e_rst_wload", 32'(bus.npu_w_load_val), 0);
    checkOutput("e_rst_busy", 32'(sched_busy), 0);
    checkOutput("e_rst_x", 32'(dut.x_count_q), 0);
    checkOutput("e_rst_w1", 32'(dut.w_count_q[1]), 0);
    @(negedge clk);
    rst = 1'b0;
    applyStimulus(2'b00, 2'b00, 2'b00, 4'h0, 16'h0000);

    // Empty mask: immediate done without leaving IDLE.
    @(negedge clk);
    cfg_start = 1'b1; cfg_req_mask = 2'b00;
    @(negedge clk);
    cfg_start = 1'b0;
    #1 checkOutput("f_done", 32'(sched_done), 1);
    checkOutput("f_busy", 32'(sched_busy), 0);
    @(negedge clk);
    #1 checkOutput("f_done_pulse", 32'(sched_done), 0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
